// File: rtl/nw_pkg.sv
// Shared types and saturating arithmetic for the affine-gap PE.
// Helpers work on a wide signed type and clamp to a runtime width.
package nw_pkg;

   localparam int WMAX = 32;
   typedef logic signed [WMAX-1:0] wscore_t;

   localparam int SCORE_W_DEF = 16;
   typedef logic signed [SCORE_W_DEF-1:0] score_t;
   localparam score_t SCORE_MIN = 16'sh8000;
   localparam score_t SCORE_MAX = 16'sh7fff;

   typedef enum logic [1:0] {
      DIR_DIAG = 2'b00,
      DIR_UP   = 2'b01,
      DIR_LEFT = 2'b10,
      DIR_ZERO = 2'b11
   } dir_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic wscore_t smin(input int w);
      logic signed [WMAX+1:0] t;
      t = -(34'sd1 <<< (w - 1));
      return wscore_t'(t);
   endfunction

   // clamp a wide intermediate into a w-bit signed range
   function automatic wscore_t sat_clip(input logic signed [WMAX+1:0] v,
                                        input int w);
      logic signed [WMAX+1:0] lo;
      logic signed [WMAX+1:0] hi;
      logic signed [WMAX+1:0] r;
      lo = -(34'sd1 <<< (w - 1));
      hi = (34'sd1 <<< (w - 1)) - 34'sd1;
      r  = v;
      if (v < lo) r = lo;
      else if (v > hi) r = hi;
      return wscore_t'(r);
   endfunction

   function automatic wscore_t sat_add(input wscore_t a, input wscore_t b,
                                       input int w);
      return sat_clip(34'(a) + 34'(b), w);
   endfunction

   function automatic wscore_t sat_sub(input wscore_t a, input wscore_t b,
                                       input int w);
      return sat_clip(34'(a) - 34'(b), w);
   endfunction

endpackage

// File: rtl/affine_score_cell.sv
// Combinational Gotoh recurrence: substitution, E, F, H and traceback dir.
// Ports: i_* neighbour scores and config, o_h/o_e/o_f scores, o_dir winner.
module affine_score_cell
   import nw_pkg::*;
#(
   parameter int SCORE_W = 16,
   parameter int CHAR_W  = 8,
   parameter int LOCAL   = 0
) (
   input  logic [CHAR_W-1:0]         i_char,
   input  logic [CHAR_W-1:0]         i_query,
   input  logic signed [SCORE_W-1:0] i_match,
   input  logic signed [SCORE_W-1:0] i_mismatch,
   input  logic signed [SCORE_W-1:0] i_open,
   input  logic signed [SCORE_W-1:0] i_extend,
   input  logic signed [SCORE_W-1:0] i_hleft,
   input  logic signed [SCORE_W-1:0] i_eleft,
   input  logic signed [SCORE_W-1:0] i_hdiag,
   input  logic signed [SCORE_W-1:0] i_hup,
   input  logic signed [SCORE_W-1:0] i_fup,
   output logic signed [SCORE_W-1:0] o_h,
   output logic signed [SCORE_W-1:0] o_e,
   output logic signed [SCORE_W-1:0] o_f,
   output dir_t                      o_dir
);

   wscore_t w_s, w_d, w_floor, w_best;
   wscore_t w_e0, w_e1, w_e;
   wscore_t w_f0, w_f1, w_f;

   always_comb begin
      w_s  = (i_char == i_query) ? WMAX'(i_match) : WMAX'(i_mismatch);
      w_d  = sat_add(WMAX'(i_hdiag), w_s, SCORE_W);
      w_e0 = sat_sub(WMAX'(i_hleft), WMAX'(i_open), SCORE_W);
      w_e1 = sat_sub(WMAX'(i_eleft), WMAX'(i_extend), SCORE_W);
      w_e  = (w_e0 >= w_e1) ? w_e0 : w_e1;
      w_f0 = sat_sub(WMAX'(i_hup), WMAX'(i_open), SCORE_W);
      w_f1 = sat_sub(WMAX'(i_fup), WMAX'(i_extend), SCORE_W);
      w_f  = (w_f0 >= w_f1) ? w_f0 : w_f1;
      w_floor = (LOCAL != 0) ? '0 : smin(SCORE_W);
      // strict compares give ties to the earlier (higher priority) term
      w_best = w_d;
      o_dir  = DIR_DIAG;
      if (w_f > w_best) begin
         w_best = w_f;
         o_dir  = DIR_UP;
      end
      if (w_e > w_best) begin
         w_best = w_e;
         o_dir  = DIR_LEFT;
      end
      if (w_floor > w_best) begin
         w_best = w_floor;
         o_dir  = DIR_ZERO;
      end
      o_h = SCORE_W'(w_best);
      o_e = SCORE_W'(w_e);
      o_f = SCORE_W'(w_f);
   end

endmodule

// File: rtl/affine_processing_unit.sv
// Affine-gap systolic PE: one query residue, one database column per beat.
// Ports: cfg_* scoring, in_*/out_* stream, best_*/done result, protocol_err.
module affine_processing_unit
   import nw_pkg::*;
#(
   parameter int SCORE_W = 16,
   parameter int CHAR_W  = 8,
   parameter int COL_W   = 12,
   parameter int LOCAL   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_load,
   input  logic [CHAR_W-1:0]         cfg_query,
   input  logic signed [SCORE_W-1:0] cfg_match,
   input  logic signed [SCORE_W-1:0] cfg_mismatch,
   input  logic signed [SCORE_W-1:0] cfg_gap_open,
   input  logic signed [SCORE_W-1:0] cfg_gap_extend,
   input  logic signed [SCORE_W-1:0] cfg_row_init,
   input  logic signed [SCORE_W-1:0] cfg_diag_init,
   input  logic                      in_valid,
   input  logic                      in_first,
   input  logic                      in_last,
   input  logic [CHAR_W-1:0]         in_char,
   input  logic signed [SCORE_W-1:0] in_h,
   input  logic signed [SCORE_W-1:0] in_f,
   output logic                      out_valid,
   output logic                      out_first,
   output logic                      out_last,
   output logic [CHAR_W-1:0]         out_char,
   output logic signed [SCORE_W-1:0] out_h,
   output logic signed [SCORE_W-1:0] out_f,
   output logic [1:0]                out_dir,
   output logic signed [SCORE_W-1:0] best_score,
   output logic [COL_W-1:0]          best_col,
   output logic                      done,
   output logic                      protocol_err
);

   localparam logic signed [SCORE_W-1:0] L_MIN =
      {1'b1, {(SCORE_W-1){1'b0}}};

   typedef logic signed [SCORE_W-1:0] sc_t;

   logic [CHAR_W-1:0] r_query;
   sc_t r_match, r_mism, r_open, r_ext, r_row, r_diag;
   sc_t r_hleft, r_eleft, r_hdiag;
   sc_t r_h, r_f, r_best;
   logic [COL_W-1:0] r_col, r_bcol;
   logic [CHAR_W-1:0] r_char;
   logic r_valid, r_first, r_last, r_done, r_perr;
   dir_t r_dir;
   state_t r_state;

   sc_t w_hleft, w_eleft, w_hdiag, w_h, w_e, w_f, w_best;
   logic [COL_W-1:0] w_col, w_bcol;
   dir_t w_dir;
   logic w_run, w_accept, w_bad;

   assign w_run    = (r_state == ST_RUN);
   // in IDLE only a first-flagged beat opens a sequence; others are dropped
   assign w_accept = in_valid & (in_first | w_run);
   assign w_bad    = in_valid & (in_first ? w_run : ~w_run);

   assign w_hleft = in_first ? r_row  : r_hleft;
   assign w_eleft = in_first ? L_MIN  : r_eleft;
   assign w_hdiag = in_first ? r_diag : r_hdiag;
   assign w_col   = in_first ? COL_W'(1) : r_col;
   assign w_best  = in_first ? '0 : r_best;
   assign w_bcol  = in_first ? '0 : r_bcol;

   affine_score_cell #(
      .SCORE_W(SCORE_W),
      .CHAR_W (CHAR_W),
      .LOCAL  (LOCAL)
   ) u_cell (
      .i_char    (in_char),
      .i_query   (r_query),
      .i_match   (r_match),
      .i_mismatch(r_mism),
      .i_open    (r_open),
      .i_extend  (r_ext),
      .i_hleft   (w_hleft),
      .i_eleft   (w_eleft),
      .i_hdiag   (w_hdiag),
      .i_hup     (in_h),
      .i_fup     (in_f),
      .o_h       (w_h),
      .o_e       (w_e),
      .o_f       (w_f),
      .o_dir     (w_dir)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_query <= '0;
         r_match <= '0;
         r_mism  <= '0;
         r_open  <= '0;
         r_ext   <= '0;
         r_row   <= '0;
         r_diag  <= '0;
         r_hleft <= '0;
         r_eleft <= L_MIN;
         r_hdiag <= '0;
         r_col   <= '0;
         r_best  <= '0;
         r_bcol  <= '0;
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
         r_char  <= '0;
         r_h     <= '0;
         r_f     <= L_MIN;
         r_dir   <= DIR_DIAG;
         r_done  <= 1'b0;
         r_perr  <= 1'b0;
         r_state <= ST_IDLE;
      end else begin
         if (cfg_load) begin
            r_query <= cfg_query;
            r_match <= cfg_match;
            r_mism  <= cfg_mismatch;
            r_open  <= cfg_gap_open;
            r_ext   <= cfg_gap_extend;
            r_row   <= cfg_row_init;
            r_diag  <= cfg_diag_init;
         end
         r_valid <= w_accept;
         r_done  <= w_accept & in_last;
         if (w_bad) r_perr <= 1'b1;
         if (w_accept) begin
            r_state <= in_last ? ST_IDLE : ST_RUN;
            r_first <= in_first;
            r_last  <= in_last;
            r_char  <= in_char;
            r_h     <= w_h;
            r_f     <= w_f;
            r_dir   <= w_dir;
            r_hleft <= w_h;
            r_eleft <= w_e;
            r_hdiag <= in_h;
            r_col   <= (&w_col) ? w_col : w_col + 1'b1;
            if (w_h > w_best) begin
               r_best <= w_h;
               r_bcol <= w_col;
            end else begin
               r_best <= w_best;
               r_bcol <= w_bcol;
            end
         end
      end
   end

   assign out_valid    = r_valid;
   assign out_first    = r_first;
   assign out_last     = r_last;
   assign out_char     = r_char;
   assign out_h        = r_h;
   assign out_f        = r_f;
   assign out_dir      = r_dir;
   assign best_score   = r_best;
   assign best_col     = r_bcol;
   assign done         = r_done;
   assign protocol_err = r_perr;

endmodule

// File: doc/affine_processing_unit.md
# affine_processing_unit

Affine-gap (Gotoh) alignment processing element for a linear systolic array. Each instance holds one query character and scores a streamed database sequence one column per cycle, forwarding the character, H and vertical-gap F to the next PE. It generalises the single-cell linear-gap unit in three ways: parametrised score width, global (Needleman-Wunsch) or local (Smith-Waterman) mode, and runtime-loaded scoring. It adds a streaming valid protocol, traceback direction output, best-score tracking and protocol-error detection.

## Interface
- SCORE_W, 16: signed score width; all score ports and registers.
- CHAR_W, 8: residue code width.
- COL_W, 12: column counter width.
- LOCAL, 0: 0 = global NW, 1 = local SW (H floored at 0).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all state.
- cfg_load  in  1  latch all cfg_* inputs this edge.
- cfg_query  in  CHAR_W  query residue for this row.
- cfg_match, cfg_mismatch  in  SCORE_W  signed substitution scores.
- cfg_gap_open, cfg_gap_extend  in  SCORE_W  non-negative penalties (subtracted); open = cost of a length-1 gap.
- cfg_row_init  in  SCORE_W  H(i,0); cfg_diag_init  in  SCORE_W  H(i-1,0).
- in_valid, in_first, in_last  in  1  beat strobe, first/last column of a sequence.
- in_char  in  CHAR_W; in_h, in_f  in  SCORE_W  H(i-1,j), F(i-1,j) from the upstream PE.
- out_valid, out_first, out_last  out  1; out_char  out  CHAR_W; out_h, out_f  out  SCORE_W  H(i,j), F(i,j).
- out_dir  out  2  00 diag, 01 up (F), 10 left (E), 11 zero (local stop).
- best_score  out  SCORE_W; best_col  out  COL_W; done  out  1; protocol_err  out  1 (sticky).

## Operation
- FSM states: IDLE (no sequence open), RUN (between in_first and in_last). IDLE->RUN on a valid beat with in_first. RUN->IDLE on a valid beat with in_last (first+last together: one-column sequence, stays IDLE).
- Per accepted beat: s = (in_char == query) ? match : mismatch; E = max(Hleft - open, Eleft - extend); F = max(in_h - open, in_f - extend); H = max(Hdiag + s, F, E, LOCAL ? 0 : SCORE_MIN).
- Tie priority: diag > up > left > zero. out_dir encodes the winning term.
- Boundary on in_first: Hleft = row_init, Eleft = SCORE_MIN, Hdiag = diag_init, column = 1, best cleared to 0 / col 0.
- After each beat: Hleft <= H, Eleft <= E, Hdiag <= in_h, column++ (saturates at 2^COL_W-1).
- Arithmetic: all add/sub saturate to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1]; SCORE_MIN never wraps positive.
- Best: update when H > best_score (strict, earliest column wins); also in global mode (final-column H is the caller's choice).
- protocol_err set on: valid beat without in_first in IDLE; in_first while in RUN (beat is still processed as a restart). Cleared only by reset.
- cfg_load: registers update at the edge; a beat in the same cycle uses the previous configuration. Loading during RUN is legal but undefined for scores.
- in_valid low: all state held, out_valid low next cycle.

## Timing
- Latency 1 cycle in_* -> out_*; throughput one column/cycle; no backpressure.
- done: one-cycle pulse coincident with out_valid & out_last; best_score/best_col valid then and held until next in_first.
- Reset values: out_valid/first/last 0, out_char 0, out_h 0, out_f SCORE_MIN, out_dir 00, best_score 0, best_col 0, done 0, protocol_err 0, FSM IDLE, cfg registers 0.
- Reset wins over any same-cycle beat or cfg_load; reset mid-sequence discards it, next beat must carry in_first.

## Structure
- Package nw_pkg: score_t, dir_t enum, SCORE_MIN/SCORE_MAX, sat_add/sat_sub functions, state enum.
- Sub-module affine_score_cell: combinational recurrence (s, E, F, H, dir) with saturation; PE wraps registers, FSM, best tracker.

## Test plan
- Global, match 2, mismatch -1, open 3, extend 1, query A, row_init -3, diag_init 0; stream A (in_h -3, in_f MIN), C (in_h -4, in_f MIN) -> out_h 2 dir 00, then -1 dir 10.
- Local, same scoring, in_h 0, in_f MIN; stream C,A,A -> out_h 0/11, 2/00, then 2 (diag 0+2 ties not, E=-1) dir 00; done with best_score 2, best_col 2.
- SCORE_W 8, in_h -128, in_f -128, open 3 -> out_f -128, no wrap; match at in_h 127 saturates 127.
- in_valid gaps of 3 cycles mid-sequence -> results identical to gapless stream.
- Beat without in_first after reset -> protocol_err 1 and stays 1; in_first in RUN -> restart, boundary values reapplied.
- Reset asserted on a beat mid-sequence -> next cycle all outputs at reset values, done never pulses.
